// File: rtl/uart_alu_host_if.sv
// Host-side bundle of the UART ALU host: transaction request, transmitter and
// receiver handshakes, and the result/status outputs.
interface uart_alu_host_if #(
  parameter int WIDTH_WORD = 8
);
  logic                  i_start;
  logic [WIDTH_WORD-1:0] i_dato_A;
  logic [WIDTH_WORD-1:0] i_dato_B;
  logic [WIDTH_WORD-1:0] i_opcode;
  logic                  o_tx_start;
  logic [WIDTH_WORD-1:0] o_data_tx;
  logic                  i_tx_done;
  logic [WIDTH_WORD-1:0] i_data_rx;
  logic                  i_rx_done;
  logic [WIDTH_WORD-1:0] o_resultado;
  logic                  o_valid;
  logic                  o_timeout;
  logic                  o_busy;

  // Driver side: the requester together with the UART transmitter/receiver.
  modport master (
    output i_start, i_dato_A, i_dato_B, i_opcode, i_tx_done, i_data_rx, i_rx_done,
    input  o_tx_start, o_data_tx, o_resultado, o_valid, o_timeout, o_busy
  );

  // The ALU host itself.
  modport slave (
    input  i_start, i_dato_A, i_dato_B, i_opcode, i_tx_done, i_data_rx, i_rx_done,
    output o_tx_start, o_data_tx, o_resultado, o_valid, o_timeout, o_busy
  );
endinterface

// File: rtl/uart_alu_host.sv
// Sends operand A, operand B and opcode over a UART transmitter, then waits
// (bounded by TIMEOUT_CYCLES) for the single result byte from the receiver.
module uart_alu_host #(
  parameter int WIDTH_WORD     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic            i_clock,
  input  logic            i_reset,
  uart_alu_host_if.slave  bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEND_A   = 3'd1;
  localparam logic [2:0] WAIT_A   = 3'd2;
  localparam logic [2:0] SEND_B   = 3'd3;
  localparam logic [2:0] WAIT_B   = 3'd4;
  localparam logic [2:0] SEND_OP  = 3'd5;
  localparam logic [2:0] WAIT_OP  = 3'd6;
  localparam logic [2:0] WAIT_RES = 3'd7;

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]            state;
  logic [WIDTH_WORD-1:0] reg_a;
  logic [WIDTH_WORD-1:0] reg_b;
  logic [WIDTH_WORD-1:0] reg_op;
  logic [CNT_W-1:0]      cnt;
  logic                  tx_start;
  logic [WIDTH_WORD-1:0] data_tx;
  logic [WIDTH_WORD-1:0] resultado;
  logic                  valid;
  logic                  timeout;

  // All outputs are registered, so each SEND state shows up on the pins one
  // cycle later, giving the two-cycle start-to-tx_start latency.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      reg_a     <= '0;
      reg_b     <= '0;
      reg_op    <= '0;
      cnt       <= '0;
      tx_start  <= 1'b0;
      data_tx   <= '0;
      resultado <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            reg_a  <= bus.i_dato_A;
            reg_b  <= bus.i_dato_B;
            reg_op <= bus.i_opcode;
            state  <= SEND_A;
          end
        end
        SEND_A: begin
          tx_start <= 1'b1;
          data_tx  <= reg_a;
          state    <= WAIT_A;
        end
        WAIT_A: if (bus.i_tx_done) state <= SEND_B;
        SEND_B: begin
          tx_start <= 1'b1;
          data_tx  <= reg_b;
          state    <= WAIT_B;
        end
        WAIT_B: if (bus.i_tx_done) state <= SEND_OP;
        SEND_OP: begin
          tx_start <= 1'b1;
          data_tx  <= reg_op;
          state    <= WAIT_OP;
        end
        WAIT_OP: begin
          if (bus.i_tx_done) begin
            cnt   <= '0;
            state <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          // A result arriving on the terminal count still wins over timeout.
          if (bus.i_rx_done) begin
            resultado <= bus.i_data_rx;
            valid     <= 1'b1;
            state     <= IDLE;
          end else if (cnt == CNT_LAST) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_tx_start  = tx_start;
  assign bus.o_data_tx   = data_tx;
  assign bus.o_resultado = resultado;
  assign bus.o_valid     = valid;
  assign bus.o_timeout   = timeout;
  assign bus.o_busy      = (state != IDLE);
endmodule
